multi_port_fifo: RTL and testbench
==================================

# multi_port_fifo

- Parametrised multi-port successor to the single-port FIFO: accepts up to WR_PORTS entries and releases up to RD_PORTS entries per cycle.
- Read side is first-word-fall-through: the oldest entries are always visible without a read request.
- Provides a single-cycle flush and reports occupancy and free-slot counts.
- Sits between fetch/decode and rename/dispatch in the out-of-order core, and serves as the instruction/micro-op buffer for superscalar widths.

## Interface
Parameters:
- T, logic [31:0], entry type.
- DEPTH, 16, number of entries; power of two, ≥ max(WR_PORTS, RD_PORTS).
- WR_PORTS, 2, maximum pushes per cycle (≥1).
- RD_PORTS, 2, maximum pops per cycle (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all control state immediately.
- flush  in  1  synchronous clear of all contents.
- write_num  in  $clog2(WR_PORTS+1)  number of entries pushed this cycle, taken from lanes 0..write_num-1.
- write_data  in  T [WR_PORTS]  push lanes; lane 0 is the oldest.
- read_num  in  $clog2(RD_PORTS+1)  number of entries popped this cycle.
- read_valid  out  RD_PORTS  bit i set when count > i.
- read_data  out  T [RD_PORTS]  lane i = entry at read_ptr+i (mod DEPTH); don't-care when read_valid[i]=0.
- count  out  $clog2(DEPTH)+1  current occupancy.
- free_slots  out  $clog2(DEPTH)+1  DEPTH - count.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- push_drop  out  1  one-cycle pulse: the push group was rejected.
- pop_underflow  out  1  one-cycle pulse: read_num > count.

## Operation
State:
- read_ptr, write_ptr: $clog2(DEPTH) bits, wrap modulo DEPTH.
- count: $clog2(DEPTH)+1 bits.
- storage: DEPTH×T, not reset.

Push (all-or-nothing):
- Accepted iff write_num ≤ free_slots, using the start-of-cycle value.
- On accept: lanes 0..write_num-1 are written to write_ptr..write_ptr+write_num-1 (mod DEPTH), and write_ptr += write_num.
- On reject (write_num > free_slots): nothing is written, pointers are unchanged, push_drop = 1 next cycle.

Pop:
- pop_n = min(read_num, start-of-cycle count); read_ptr += pop_n.
- If read_num > count: pop_underflow = 1 next cycle, and only count entries are popped.

Count update:
- count_next = count + push_n - pop_n, where push_n = write_num if accepted, else 0.

Simultaneous push/pop:
- Both are evaluated against start-of-cycle state.
- Slots freed by a same-cycle pop are not available to a same-cycle push, so a full FIFO with read_num=2 and write_num=1 drops the push.
- Entries pushed into an empty FIFO cannot be popped in the same cycle.

Flush:
- read_ptr, write_ptr and count are cleared to 0 at the next edge.
- Flush overrides any same-cycle push or pop.
- push_drop and pop_underflow are forced to 0 in the cycle after a flush.

Reset (asynchronous, any time, including mid-operation):
- Pointers and count = 0.
- read_valid = 0, empty = 1, full = 0, count = 0, free_slots = DEPTH.
- push_drop = 0, pop_underflow = 0.
- Storage contents are unchanged but unreachable.

## Timing
- Push-to-visibility latency: 1 cycle. An entry written at edge N appears on read_data/read_valid after edge N.
- read_data and read_valid are combinational from read_ptr, count and storage; there is no registered read stage.
- count, free_slots, full and empty are combinational from the count register and update after each edge.
- push_drop and pop_underflow are registered and last one cycle.
- Throughput: WR_PORTS pushes plus RD_PORTS pops per cycle, sustained while neither the full nor the empty limit is hit.
- Wrap-around: a multi-entry write or read that crosses index DEPTH-1 continues at index 0, with no bubble.

## Test plan
- Reset mid-stream: push 5 entries, assert reset asynchronously between edges → outputs go immediately to count=0, empty=1, read_valid=0, free_slots=16; after release, a push of 2 entries gives count=2.
- Fill and overflow: push 2 per cycle for 8 cycles (values 0..15) → full=1, count=16. Then push 1 with read_num=1 in the same cycle → push_drop=1, count=15, read_data[0]=1.
- Partial room reject: with count=15, write_num=2 → push_drop=1, count stays 15, no entry written. write_num=1 → accepted, count=16.
- Wrap-around ordering: repeatedly push 2 and pop 2 for 20 cycles with incrementing data → read_data[0], read_data[1] stay strictly sequential across the index 15→0 boundary; count stays 2 after the first cycle.
- Underflow: count=1, read_num=2 → pop_underflow=1, count=0, empty=1, read_ptr advanced by 1 only.
- Flush priority: count=6, assert flush with write_num=2 and read_num=2 → next cycle count=0, empty=1, push_drop=0. The next push of A,B → read_data[0]=A, read_data[1]=B.

Source files
------------

// File: rtl/multi_port_fifo.sv
// multi_port_fifo
//   Multi-port, first-word-fall-through FIFO used as the instruction/micro-op
//   buffer between fetch/decode and rename/dispatch. Accepts up to WR_PORTS
//   entries and releases up to RD_PORTS entries per cycle.
//
// Ports
//   clk           : clock, all state updates on posedge
//   reset         : asynchronous active-high reset of control state
//   flush         : synchronous clear of all contents (wins over push/pop)
//   write_num     : number of lanes pushed this cycle (lanes 0..write_num-1)
//   write_data    : push lanes, lane 0 is the oldest
//   read_num      : number of entries popped this cycle
//   read_valid    : bit i set when count > i
//   read_data     : lane i = entry at read_ptr+i (mod DEPTH)
//   count         : current occupancy
//   free_slots    : DEPTH - count
//   full / empty  : count == DEPTH / count == 0
//   push_drop     : one-cycle pulse, previous cycle's push group was rejected
//   pop_underflow : one-cycle pulse, previous cycle's read_num exceeded count
module multi_port_fifo #(
    parameter type T        = logic [31:0],
    parameter int  DEPTH    = 16,
    parameter int  WR_PORTS = 2,
    parameter int  RD_PORTS = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [$clog2(WR_PORTS+1)-1:0]   write_num,
    input  T                                write_data [WR_PORTS],
    input  logic [$clog2(RD_PORTS+1)-1:0]   read_num,
    output logic [RD_PORTS-1:0]             read_valid,
    output T                                read_data [RD_PORTS],
    output logic [$clog2(DEPTH):0]          count,
    output logic [$clog2(DEPTH):0]          free_slots,
    output logic                            full,
    output logic                            empty,
    output logic                            push_drop,
    output logic                            pop_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_drop_q, push_drop_d;
    logic             pop_underflow_q, pop_underflow_d;

    // Storage is never reset; after reset it is simply unreachable.
    T mem_q [DEPTH];

    logic             push_ok;
    logic             underflow;
    logic [CNT_W-1:0] free_w;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;

    // Push and pop are both judged against start-of-cycle state, so slots
    // freed by a same-cycle pop never make room for a same-cycle push, and
    // entries pushed this cycle cannot be popped this cycle.
    always_comb begin
        free_w    = CNT_W'(DEPTH) - count_q;
        push_ok   = (CNT_W'(write_num) <= free_w);
        push_n    = push_ok ? CNT_W'(write_num) : '0;
        underflow = (CNT_W'(read_num) > count_q);
        pop_n     = underflow ? count_q : CNT_W'(read_num);
    end

    always_comb begin
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        push_drop_d     = 1'b0;
        pop_underflow_d = 1'b0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointer adds wrap naturally at DEPTH (power of two); a pop of
            // exactly DEPTH entries truncates to a zero advance, as intended.
            wr_ptr_d        = wr_ptr_q + PTR_W'(push_n);
            rd_ptr_d        = rd_ptr_q + PTR_W'(pop_n);
            count_d         = count_q + push_n - pop_n;
            push_drop_d     = ~push_ok;
            pop_underflow_d = underflow;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            push_drop_q     <= 1'b0;
            pop_underflow_q <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            push_drop_q     <= push_drop_d;
            pop_underflow_q <= pop_underflow_d;
        end
    end

    // Accepted lanes land at consecutive slots from wr_ptr, wrapping past
    // DEPTH-1 without a bubble. Rejected groups and flush write nothing.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (i < int'(write_num)) begin
                    mem_q[wr_ptr_q + PTR_W'(i)] <= write_data[i];
                end
            end
        end
    end

    // Fall-through read lanes: purely combinational from rd_ptr, count and
    // storage, no registered read stage.
    always_comb begin
        for (int i = 0; i < RD_PORTS; i++) begin
            read_data[i]  = mem_q[rd_ptr_q + PTR_W'(i)];
            read_valid[i] = (count_q > CNT_W'(i));
        end
    end

    assign count         = count_q;
    assign free_slots    = free_w;
    assign full          = (count_q == CNT_W'(DEPTH));
    assign empty         = (count_q == '0);
    assign push_drop     = push_drop_q;
    assign pop_underflow = pop_underflow_q;

endmodule

// File: tb/tb_multi_port_fifo.sv
module tb_multi_port_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  write_num;
    logic [31:0] write_data [2];
    logic [1:0]  read_num;
    logic [1:0]  read_valid;
    logic [31:0] read_data [2];
    logic [4:0]  count;
    logic [4:0]  free_slots;
    logic        full;
    logic        empty;
    logic        push_drop;
    logic        pop_underflow;

    int checks = 0;
    int errors = 0;

    multi_port_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .write_num     (write_num),
        .write_data    (write_data),
        .read_num      (read_num),
        .read_valid    (read_valid),
        .read_data     (read_data),
        .count         (count),
        .free_slots    (free_slots),
        .full          (full),
        .empty         (empty),
        .push_drop     (push_drop),
        .pop_underflow (pop_underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, then return #1 after the edge with idle inputs.
    task automatic cycle(input int wn, input int rn, input logic [31:0] d0,
                         input logic [31:0] d1, input logic fl);
        write_num     = 2'(wn);
        read_num      = 2'(rn);
        write_data[0] = d0;
        write_data[1] = d1;
        flush         = fl;
        @(posedge clk);
        #1;
        write_num = 2'd0;
        read_num  = 2'd0;
        flush     = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        flush = 1'b0;
        write_num = 2'd0;
        read_num = 2'd0;
        write_data[0] = '0;
        write_data[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || free_slots !== 5'd16 ||
            read_valid !== 2'b00 || push_drop !== 1'b0 || pop_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b free=%0d rv=%b drop=%b unf=%b, expected 0 1 0 16 00 0 0",
                     count, empty, full, free_slots, read_valid, push_drop, pop_underflow);
        end
        // Mid-stream asynchronous reset.
        cycle(2, 0, 32'h10, 32'h11, 1'b0);
        cycle(2, 0, 32'h12, 32'h13, 1'b0);
        cycle(1, 0, 32'h14, 32'h0, 1'b0);
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL reset_prefill_count: got %0d expected 5", count);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || read_valid !== 2'b00 || free_slots !== 5'd16) begin
            errors++;
            $display("FAIL reset_async: count=%0d empty=%b rv=%b free=%0d, expected 0 1 00 16",
                     count, empty, read_valid, free_slots);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(2, 0, 32'hA0, 32'hA1, 1'b0);
        checks++;
        if (count !== 5'd2 || read_data[0] !== 32'hA0 || read_data[1] !== 32'hA1) begin
            errors++;
            $display("FAIL reset_after_push: count=%0d rd0=%h rd1=%h, expected 2 a0 a1",
                     count, read_data[0], read_data[1]);
        end
    endtask

    task automatic test_fill_overflow;
        cycle(0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 8; k++) cycle(2, 0, 32'(2*k), 32'(2*k+1), 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || free_slots !== 5'd0 ||
            read_data[0] !== 32'd0 || read_data[1] !== 32'd1 || read_valid !== 2'b11) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d free=%0d rd0=%0d rd1=%0d rv=%b, expected 1 16 0 0 1 11",
                     full, count, free_slots, read_data[0], read_data[1], read_valid);
        end
        cycle(1, 1, 32'd99, 32'd0, 1'b0);
        checks++;
        if (push_drop !== 1'b1 || count !== 5'd15 || read_data[0] !== 32'd1 || full !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drop: drop=%b count=%0d rd0=%0d full=%b, expected 1 15 1 0",
                     push_drop, count, read_data[0], full);
        end
    endtask

    task automatic test_partial_reject;
        cycle(2, 0, 32'hAA, 32'hBB, 1'b0);
        checks++;
        if (push_drop !== 1'b1 || count !== 5'd15) begin
            errors++;
            $display("FAIL partial_reject: drop=%b count=%0d, expected 1 15", push_drop, count);
        end
        cycle(1, 0, 32'd100, 32'd0, 1'b0);
        checks++;
        if (push_drop !== 1'b0 || count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL partial_accept: drop=%b count=%0d full=%b, expected 0 16 1", push_drop, count, full);
        end
        // Drain 14 entries (1..14); 15 and 100 must remain in order.
        for (int k = 0; k < 7; k++) cycle(0, 2, 0, 0, 1'b0);
        checks++;
        if (count !== 5'd2 || read_data[0] !== 32'd15 || read_data[1] !== 32'd100) begin
            errors++;
            $display("FAIL partial_order: count=%0d rd0=%0d rd1=%0d, expected 2 15 100",
                     count, read_data[0], read_data[1]);
        end
    endtask

    task automatic test_wrap;
        int bad;
        bad = 0;
        cycle(0, 0, 0, 0, 1'b1);
        cycle(2, 0, 32'd0, 32'd1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cycle(2, 2, 32'(2*k), 32'(2*k+1), 1'b0);
            checks++;
            if (count !== 5'd2 || read_data[0] !== 32'(2*k) || read_data[1] !== 32'(2*k+1)) begin
                errors++;
                $display("FAIL wrap_step%0d: count=%0d rd0=%0d rd1=%0d, expected 2 %0d %0d",
                         k, count, read_data[0], read_data[1], 2*k, 2*k+1);
            end
        end
    endtask

    task automatic test_underflow;
        cycle(0, 0, 0, 0, 1'b1);
        cycle(1, 0, 32'd7, 32'd0, 1'b0);
        cycle(0, 2, 0, 0, 1'b0);
        checks++;
        if (pop_underflow !== 1'b1 || count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: unf=%b count=%0d empty=%b, expected 1 0 1", pop_underflow, count, empty);
        end
        cycle(2, 0, 32'd8, 32'd9, 1'b0);
        checks++;
        if (pop_underflow !== 1'b0 || read_data[0] !== 32'd8 || read_data[1] !== 32'd9 || count !== 5'd2) begin
            errors++;
            $display("FAIL underflow_ptr: unf=%b rd0=%0d rd1=%0d count=%0d, expected 0 8 9 2",
                     pop_underflow, read_data[0], read_data[1], count);
        end
    endtask

    task automatic test_push_pop_empty;
        cycle(0, 0, 0, 0, 1'b1);
        cycle(2, 2, 32'd50, 32'd51, 1'b0);
        checks++;
        if (count !== 5'd2 || pop_underflow !== 1'b1 || push_drop !== 1'b0 || read_data[0] !== 32'd50) begin
            errors++;
            $display("FAIL empty_push_pop: count=%0d unf=%b drop=%b rd0=%0d, expected 2 1 0 50",
                     count, pop_underflow, push_drop, read_data[0]);
        end
        cycle(0, 0, 0, 0, 1'b0);
        checks++;
        if (pop_underflow !== 1'b0 || read_valid !== 2'b11) begin
            errors++;
            $display("FAIL pulse_clear: unf=%b rv=%b, expected 0 11", pop_underflow, read_valid);
        end
    endtask

    task automatic test_flush;
        cycle(0, 0, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(2, 0, 32'(k), 32'(k), 1'b0);
        checks++;
        if (count !== 5'd6) begin
            errors++;
            $display("FAIL flush_prefill: got %0d expected 6", count);
        end
        cycle(2, 2, 32'hEE, 32'hEF, 1'b1);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || push_drop !== 1'b0 || pop_underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: count=%0d empty=%b drop=%b unf=%b, expected 0 1 0 0",
                     count, empty, push_drop, pop_underflow);
        end
        cycle(2, 0, 32'hA, 32'hB, 1'b0);
        checks++;
        if (read_data[0] !== 32'hA || read_data[1] !== 32'hB || count !== 5'd2) begin
            errors++;
            $display("FAIL flush_repush: rd0=%h rd1=%h count=%0d, expected a b 2",
                     read_data[0], read_data[1], count);
        end
        // Flush in the cycle a drop would have happened suppresses the pulse.
        for (int k = 0; k < 7; k++) cycle(2, 0, 0, 0, 1'b0);
        cycle(1, 0, 0, 0, 1'b1);
        checks++;
        if (push_drop !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_drop_mask: drop=%b empty=%b, expected 0 1", push_drop, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_partial_reject();
        test_wrap();
        test_underflow();
        test_push_pop_empty();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
